// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with run/pause/done FSM and a registered terminal-count pulse.
// Define COUNTDOWN_RELOAD_EN for auto-reload (periodic tick) mode; undefined gives one-shot behaviour.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             tc
);
`ifdef COUNTDOWN_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] rld_q, out_d, eff;
  logic tc_d;
  assign eff = load ? load_val : rld_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rld_q <= '0;
      out <= '0;
      tc <= 1'b0;
    end else begin
      if (load) rld_q <= load_val;
      out <= out_d;
      tc <= tc_d;
    end
  always_comb begin
    state_d = state;
    out_d = out;
    tc_d = 1'b0;
    case (state)
      IDLE, DONE:
        if (state == DONE && stop) begin
          state_d = IDLE;
          out_d = rld_q;
        end else if (start && !stop) begin
          out_d = eff;
          tc_d = eff == '0;
          state_d = (eff == '0 && !RELOAD) ? DONE : RUN;
        end else if (state == IDLE && load) out_d = load_val;
      RUN:
        if (stop) state_d = PAUSE;
        else if (out == '0) begin
          // reached only in reload mode: a zero reload value keeps tc asserted
          out_d = rld_q;
          tc_d = rld_q == '0;
        end else begin
          out_d = out - ONE;
          tc_d = out == ONE;
          state_d = (out == ONE && !RELOAD) ? DONE : RUN;
        end
      PAUSE:
        if (stop) begin
          state_d = IDLE;
          out_d = rld_q;
        end else if (start) state_d = RUN;
    endcase
  end
  always_comb begin
    busy = state == RUN || state == PAUSE;
    done = state == DONE;
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: vector table, corner sequences and randomized run against a rule-level model.
module tb_countdown_timer;
  localparam int W = 4;
`ifdef COUNTDOWN_RELOAD_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [W-1:0] load_val = '0, out;
  logic busy, done, tc;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  countdown_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .stop(stop),
    .out(out), .busy(busy), .done(done), .tc(tc)
  );
  typedef struct {
    logic l; logic [W-1:0] lv; logic s; logic p;
    logic [W-1:0] o; logic b; logic d; logic t;
  } vec_t;
  vec_t tbl[$];
  // model: mode 0 idle, 1 counting, 2 paused, 3 finished
  int m_mode;
  logic [W-1:0] m_out, m_rld;
  logic m_tc;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic add(input int l, lv, s, p, o, b, d, t);
    vec_t v;
    v.l = 1'(l); v.lv = W'(lv); v.s = 1'(s); v.p = 1'(p);
    v.o = W'(o); v.b = 1'(b); v.d = 1'(d); v.t = 1'(t);
    tbl.push_back(v);
  endtask
  task automatic model_reset();
    m_mode = 0; m_out = '0; m_rld = '0; m_tc = 1'b0;
  endtask
  task automatic model_go(input logic [W-1:0] v, output logic nt);
    m_out = v;
    nt = (v == 0);
    m_mode = (v == 0 && !RL) ? 3 : 1;
  endtask
  task automatic model_step();
    logic [W-1:0] v;
    logic nt;
    v = load ? load_val : m_rld;
    nt = 1'b0;
    if (m_mode == 0) begin
      if (start && !stop) model_go(v, nt);
      else if (load) m_out = load_val;
    end else if (m_mode == 1) begin
      if (stop) m_mode = 2;
      else if (m_out == 0) begin
        m_out = m_rld;
        nt = (m_rld == 0);
      end else begin
        m_out = m_out - 1'b1;
        nt = (m_out == 0);
        if (nt && !RL) m_mode = 3;
      end
    end else if (stop) begin
      m_mode = 0;
      m_out = m_rld;
    end else if (start) begin
      if (m_mode == 2) m_mode = 1;
      else model_go(v, nt);
    end
    if (load) m_rld = load_val;
    m_tc = nt;
  endtask
  task automatic step(input logic l, input logic [W-1:0] lv, input logic s, input logic p);
    load = l; load_val = lv; start = s; stop = p;
    @(posedge clk);
    model_step();
    #1;
    chk("model_out", 32'(out), 32'(m_out));
    chk("model_busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
    chk("model_done", 32'(done), 32'(m_mode == 3));
    chk("model_tc", 32'(tc), 32'(m_tc));
  endtask
  initial begin
    int first, second;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 32'(out), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_tc", 32'(tc), 0);
    @(negedge clk) rst = 1'b0;
    step(0, 0, 1, 0);
    chk("rst_start_tc", 32'(tc), 1);
    chk("rst_start_done", 32'(done), 32'(!RL));
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
`ifdef COUNTDOWN_RELOAD_EN
    add(1,3,0,0, 3,0,0,0); add(0,0,1,0, 3,1,0,0); add(0,0,0,0, 2,1,0,0);
    add(0,0,0,0, 1,1,0,0); add(0,0,0,0, 0,1,0,1); add(0,0,0,0, 3,1,0,0);
    add(0,0,0,0, 2,1,0,0); add(0,0,0,0, 1,1,0,0); add(0,0,0,0, 0,1,0,1);
    add(0,0,0,0, 3,1,0,0); add(1,0,0,0, 2,1,0,0); add(0,0,0,0, 1,1,0,0);
    add(0,0,0,0, 0,1,0,1); add(0,0,0,0, 0,1,0,1); add(0,0,0,0, 0,1,0,1);
    add(0,0,0,1, 0,1,0,0); add(0,0,0,1, 0,0,0,0);
`else
    add(1,5,0,0, 5,0,0,0); add(0,0,1,0, 5,1,0,0); add(0,0,0,0, 4,1,0,0);
    add(0,0,0,0, 3,1,0,0); add(0,0,0,0, 2,1,0,0); add(0,0,0,0, 1,1,0,0);
    add(0,0,0,0, 0,0,1,1); add(0,0,0,0, 0,0,1,0); add(1,9,1,0, 9,1,0,0);
    add(0,0,0,0, 8,1,0,0); add(0,0,0,0, 7,1,0,0); add(0,0,0,0, 6,1,0,0);
    add(0,0,0,1, 6,1,0,0); add(0,0,0,0, 6,1,0,0); add(0,0,0,0, 6,1,0,0);
    add(0,0,1,0, 6,1,0,0); add(0,0,0,0, 5,1,0,0); add(0,0,0,0, 4,1,0,0);
    add(0,0,1,1, 4,1,0,0); add(0,0,0,1, 9,0,0,0); add(1,3,1,0, 3,1,0,0);
    add(1,7,0,0, 2,1,0,0); add(0,0,0,0, 1,1,0,0); add(0,0,0,0, 0,0,1,1);
    add(0,0,1,0, 7,1,0,0); add(0,0,0,1, 7,1,0,0); add(0,0,0,1, 7,0,0,0);
    add(1,0,0,0, 0,0,0,0); add(0,0,1,0, 0,0,1,1); add(0,0,0,0, 0,0,1,0);
    add(0,0,0,1, 0,0,0,0); add(0,0,0,1, 0,0,0,0);
`endif
    foreach (tbl[i]) begin
      step(tbl[i].l, tbl[i].lv, tbl[i].s, tbl[i].p);
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].o));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].d));
      chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(tbl[i].t));
    end
    first = -1;
    second = -1;
    step(1, 15, 1, 0);
    for (int c = 1; c <= 40; c++) begin
      step(0, 0, 0, 0);
      if (tc && first < 0) first = c;
      else if (tc && second < 0) second = c;
    end
    chk("p15_first_tc", 32'(first), 15);
    if (RL) chk("p15_period", 32'(second - first), 16);
    else begin
      chk("p15_single_tc", 32'(second), 32'(-1));
      chk("p15_done", 32'(done), 1);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 9, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("pre_rst_out", 32'(out), 6);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(out), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_tc", 32'(tc), 0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    repeat (600)
      step($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
